// File: rtl/periph_bus_bridge.sv
// Peripheral bus bridge: decodes a slot from addr[SLOT_SHIFT+3:SLOT_SHIFT] and forwards the core request to that slave.
// Response is 2+ cycles after sampling (1 on decode error); silent slaves are aborted after TIMEOUT_CYCLES with ERROR_DATA.
module periph_bus_bridge #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned SLOT_SHIFT     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     peripheral_read_request,
  input  logic                     peripheral_write_request,
  input  logic [31:0]              peripheral_addr,
  input  logic [31:0]              peripheral_write_data,
  output logic [31:0]              peripheral_read_data,
  output logic                     peripheral_response,
  output logic [NUM_SLAVES-1:0]    slave_read_request,
  output logic [NUM_SLAVES-1:0]    slave_write_request,
  output logic [31:0]              slave_addr,
  output logic [31:0]              slave_write_data,
  input  logic [32*NUM_SLAVES-1:0] slave_read_data,
  input  logic [NUM_SLAVES-1:0]    slave_response,
  output logic                     bus_error,
  output logic [31:0]              error_addr
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_ERR,
    ST_HOLDOFF
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_write_q, is_write_d;
  logic [SEL_W-1:0]      slot_q, slot_d;
  logic [NUM_SLAVES-1:0] rd_req_d, wr_req_d;
  logic [31:0]           addr_d, wdata_d, rdata_d, err_addr_d;
  logic                  resp_d, bus_err_d;

  logic [3:0]            req_slot;
  logic                  slot_ok;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic [31:0]           slot_rdata [NUM_SLAVES];

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rdata
    assign slot_rdata[g] = slave_read_data[32*g +: 32];
  end

  assign req_slot = peripheral_addr[SLOT_SHIFT+3:SLOT_SHIFT];
  // Compare in 5 bits so NUM_SLAVES=16 does not overflow the 4-bit field.
  assign slot_ok  = ({1'b0, req_slot} < 5'(NUM_SLAVES));

  always_comb begin
    req_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      req_onehot[i] = (req_slot == 4'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    slot_d     = slot_q;
    rd_req_d   = slave_read_request;
    wr_req_d   = slave_write_request;
    addr_d     = slave_addr;
    wdata_d    = slave_write_data;
    rdata_d    = peripheral_read_data;
    err_addr_d = error_addr;
    resp_d     = 1'b0;
    bus_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (peripheral_read_request || peripheral_write_request) begin
          addr_d     = peripheral_addr;
          wdata_d    = peripheral_write_data;
          is_write_d = peripheral_write_request;
          slot_d     = req_slot[SEL_W-1:0];
          if ((peripheral_read_request && peripheral_write_request) || !slot_ok) begin
            state_d    = ST_ERR;
            resp_d     = 1'b1;
            bus_err_d  = 1'b1;
            rdata_d    = ERROR_DATA;
            err_addr_d = peripheral_addr;
          end else begin
            state_d  = ST_WAIT;
            cnt_d    = '0;
            rd_req_d = peripheral_write_request ? '0 : req_onehot;
            wr_req_d = peripheral_write_request ? req_onehot : '0;
          end
        end
      end
      ST_WAIT: begin
        // A response in the same cycle as the timeout still completes normally.
        if (slave_response[slot_q]) begin
          state_d  = ST_RESP;
          rd_req_d = '0;
          wr_req_d = '0;
          resp_d   = 1'b1;
          if (!is_write_q) rdata_d = slot_rdata[slot_q];
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d    = ST_ERR;
          rd_req_d   = '0;
          wr_req_d   = '0;
          resp_d     = 1'b1;
          bus_err_d  = 1'b1;
          rdata_d    = ERROR_DATA;
          err_addr_d = slave_addr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP:    state_d = ST_HOLDOFF;
      ST_ERR:     state_d = ST_HOLDOFF;
      ST_HOLDOFF: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= ST_IDLE;
      cnt_q                <= '0;
      is_write_q           <= 1'b0;
      slot_q               <= '0;
      slave_read_request   <= '0;
      slave_write_request  <= '0;
      slave_addr           <= '0;
      slave_write_data     <= '0;
      peripheral_read_data <= '0;
      peripheral_response  <= 1'b0;
      bus_error            <= 1'b0;
      error_addr           <= '0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      is_write_q           <= is_write_d;
      slot_q               <= slot_d;
      slave_read_request   <= rd_req_d;
      slave_write_request  <= wr_req_d;
      slave_addr           <= addr_d;
      slave_write_data     <= wdata_d;
      peripheral_read_data <= rdata_d;
      peripheral_response  <= resp_d;
      bus_error            <= bus_err_d;
      error_addr           <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Randomized bench for periph_bus_bridge: a per-transaction latency/result model checks every cycle.
module tb_periph_bus_bridge;

  localparam int          NS    = 4;
  localparam int          TO    = 8;
  localparam logic [31:0] ERR_D = 32'hDEADBEEF;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            peripheral_read_request = 1'b0;
  logic            peripheral_write_request = 1'b0;
  logic [31:0]     peripheral_addr = '0;
  logic [31:0]     peripheral_write_data = '0;
  logic [31:0]     peripheral_read_data;
  logic            peripheral_response;
  logic [NS-1:0]   slave_read_request;
  logic [NS-1:0]   slave_write_request;
  logic [31:0]     slave_addr;
  logic [31:0]     slave_write_data;
  logic [32*NS-1:0] slave_read_data = '0;
  logic [NS-1:0]   slave_response = '0;
  logic            bus_error;
  logic [31:0]     error_addr;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_rdata    = '0;
  logic [31:0] exp_err_addr = '0;

  periph_bus_bridge #(
    .NUM_SLAVES    (NS),
    .SLOT_SHIFT    (16),
    .TIMEOUT_CYCLES(TO),
    .ERROR_DATA    (ERR_D)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .peripheral_read_request (peripheral_read_request),
    .peripheral_write_request(peripheral_write_request),
    .peripheral_addr         (peripheral_addr),
    .peripheral_write_data   (peripheral_write_data),
    .peripheral_read_data    (peripheral_read_data),
    .peripheral_response     (peripheral_response),
    .slave_read_request      (slave_read_request),
    .slave_write_request     (slave_write_request),
    .slave_addr              (slave_addr),
    .slave_write_data        (slave_write_data),
    .slave_read_data         (slave_read_data),
    .slave_response          (slave_response),
    .bus_error               (bus_error),
    .error_addr              (error_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // dly: request cycle (0 = first) in which the target slave responds; > TO means silent.
  // hold: 0 = core drops request right after sampling, 1 = on response, 2 = two cycles after response.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int dly, input int hold, input bit noise);
    int slot, lat, nsl;
    bit dec_ok, ok;
    logic [NS-1:0] onehot, exp_rd, exp_wr;
    slot   = int'(addr[19:16]);
    dec_ok = (rd != wr) && (slot < NS);
    ok     = dec_ok && (dly <= TO);
    lat    = !dec_ok ? 1 : (ok ? dly + 2 : TO + 2);
    onehot = dec_ok ? NS'(1 << slot) : '0;

    check("read_data_held", peripheral_read_data, exp_rdata);
    check("error_addr_held", error_addr, exp_err_addr);

    for (int s = 0; s < NS; s++) slave_read_data[32*s +: 32] = $urandom;
    if (dec_ok) slave_read_data[32*slot +: 32] = rdata;
    peripheral_read_request  = rd;
    peripheral_write_request = wr;
    peripheral_addr          = addr;
    peripheral_write_data    = wdata;

    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      exp_rd = (dec_ok && !wr && k <= lat - 1) ? onehot : '0;
      exp_wr = (dec_ok &&  wr && k <= lat - 1) ? onehot : '0;
      check("slave_read_request", slave_read_request, exp_rd);
      check("slave_write_request", slave_write_request, exp_wr);
      check("peripheral_response", peripheral_response, k == lat);
      check("bus_error", bus_error, (k == lat) && !ok);
      if (exp_rd != '0 || exp_wr != '0) begin
        check("slave_addr", slave_addr, addr);
        if (wr) check("slave_write_data", slave_write_data, wdata);
      end
      if (k == lat) begin
        if (!ok) begin
          exp_rdata    = ERR_D;
          exp_err_addr = addr;
        end else if (!wr) begin
          exp_rdata = rdata;
        end
        check("read_data", peripheral_read_data, exp_rdata);
        check("error_addr", error_addr, exp_err_addr);
      end

      slave_response = '0;
      if (noise && $urandom_range(0, 1) == 1) begin
        nsl = dec_ok ? (slot + 1 + int'($urandom_range(0, NS - 2))) % NS
                     : int'($urandom_range(0, NS - 1));
        slave_response[nsl] = 1'b1;
        slave_read_data[32*nsl +: 32] = $urandom;
      end
      if (dec_ok && k == dly + 1) slave_response[slot] = 1'b1;
      if ((hold == 0 && k == 1) || (hold == 1 && k == lat) || (hold == 2 && k == lat + 2)) begin
        peripheral_read_request  = 1'b0;
        peripheral_write_request = 1'b0;
      end
    end
    slave_response           = '0;
    peripheral_read_request  = 1'b0;
    peripheral_write_request = 1'b0;
  endtask

  task automatic reset_mid();
    peripheral_read_request = 1'b1;
    peripheral_addr         = 32'h8002_0040;
    repeat (3) @(negedge clk);
    check("pre_reset_read_request", slave_read_request, NS'(4'b0100));
    rst_n = 1'b0;
    #1;
    exp_rdata    = '0;
    exp_err_addr = '0;
    check("rst_slave_read_request", slave_read_request, '0);
    check("rst_slave_write_request", slave_write_request, '0);
    check("rst_peripheral_response", peripheral_response, 1'b0);
    check("rst_bus_error", bus_error, 1'b0);
    check("rst_read_data", peripheral_read_data, exp_rdata);
    check("rst_error_addr", error_addr, exp_err_addr);
    check("rst_slave_addr", slave_addr, '0);
    peripheral_read_request = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic rd, wr;
    int slot, dly;
    logic [31:0] addr;

    repeat (3) @(negedge clk);
    check("reset_read_data", peripheral_read_data, '0);
    check("reset_response", peripheral_response, 1'b0);
    check("reset_read_request", slave_read_request, '0);
    check("reset_write_request", slave_write_request, '0);
    check("reset_slave_addr", slave_addr, '0);
    check("reset_slave_write_data", slave_write_data, '0);
    check("reset_bus_error", bus_error, 1'b0);
    check("reset_error_addr", error_addr, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 1'b0, 32'h8001_0010, 32'h0, 32'h1234_5678, 0, 1, 1'b0);
    run_txn(1'b0, 1'b1, 32'h8000_0004, 32'hA5A5_A5A5, $urandom, 5, 2, 1'b0);
    run_txn(1'b1, 1'b0, 32'h8007_0000, 32'h0, $urandom, 0, 1, 1'b0);
    run_txn(1'b1, 1'b0, 32'h8002_0020, 32'h0, $urandom, 100, 1, 1'b0);
    run_txn(1'b1, 1'b0, 32'h8002_0024, 32'h0, 32'h0BAD_F00D, TO, 1, 1'b0);
    run_txn(1'b1, 1'b0, 32'h8001_0100, 32'h0, 32'hCAFE_0001, 6, 1, 1'b1);
    run_txn(1'b1, 1'b1, 32'h8003_0008, 32'h1111_2222, $urandom, 0, 1, 1'b0);
    run_txn(1'b0, 1'b1, 32'h8003_000C, 32'h3333_4444, $urandom, 2, 0, 1'b1);
    reset_mid();
    run_txn(1'b1, 1'b0, 32'h8000_0008, 32'h0, 32'h5555_AAAA, 2, 1, 1'b0);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 99) < 5) begin
        rd = 1'b1;
        wr = 1'b1;
      end else begin
        rd = 1'($urandom_range(0, 1));
        wr = !rd;
      end
      slot = ($urandom_range(0, 99) < 15) ? int'($urandom_range(NS, 15)) : int'($urandom_range(0, NS - 1));
      addr = {1'b1, 11'($urandom), 4'(slot), 16'($urandom)};
      dly  = ($urandom_range(0, 99) < 20) ? 100 : int'($urandom_range(0, TO));
      run_txn(rd, wr, addr, $urandom, $urandom, dly, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
